// File: rtl/half_norm.sv
// Normalize / round-to-nearest-even / pack stage for the FP16 adder: one renormalization shift per cycle.
// Optional macro HALF_NORM_FTZ_EN flushes subnormal results to signed zero.
module half_norm (
    input  logic        clk,
    input  logic        nrst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [4:0]  in_exp,
    input  logic [13:0] in_mant,
    output logic [15:0] out,
    output logic        out_valid,
    input  logic        out_ready
);

`ifdef HALF_NORM_FTZ_EN
    localparam logic FTZ = 1'b1;
`else
    localparam logic FTZ = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, RSHIFT, LSHIFT, ROUND, DONE} state_t;

    state_t        state, state_nxt;
    logic          sign, sign_nxt;
    logic [5:0]    exp, exp_nxt;
    logic [13:0]   mant, mant_nxt;
    logic [15:0]   out_nxt;
    logic [13:0]   mant_sh;
    logic [5:0]    exp_dec;
    logic [5:0]    exp_inc;

    // Round-to-nearest-even on mant[12:2] with guard mant[1] and sticky mant[0], then pack.
    function automatic logic [15:0] round_pack(input logic s, input logic [5:0] e, input logic [13:0] m);
        logic        inc;
        logic [11:0] m12;
        logic [5:0]  e_r;
        logic [4:0]  field;
        inc = m[1] & (m[0] | m[2]);
        m12 = {1'b0, m[12:2]} + {11'd0, inc};
        e_r = e;
        if (m12[11]) begin
            e_r = e + 6'd1;
            m12 = 12'h400;
        end
        if (e_r >= 6'd31) begin
            round_pack = {s, 5'h1F, 10'h000};
        end else begin
            // No hidden bit after rounding means the result stays subnormal.
            field      = m12[10] ? e_r[4:0] : 5'd0;
            round_pack = {s, field, m12[9:0]};
        end
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign mant_sh   = {mant[12:0], 1'b0};
    assign exp_dec   = exp - 6'd1;
    assign exp_inc   = exp + 6'd1;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
            out   <= 16'h0000;
        end else begin
            state <= state_nxt;
            out   <= out_nxt;
        end
    end

    always_ff @(posedge clk) begin
        sign <= sign_nxt;
        exp  <= exp_nxt;
        mant <= mant_nxt;
    end

    always_comb begin
        state_nxt = state;
        sign_nxt  = sign;
        exp_nxt   = exp;
        mant_nxt  = mant;
        out_nxt   = out;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    sign_nxt = in_sign;
                    exp_nxt  = (in_exp == 5'd0) ? 6'd1 : {1'b0, in_exp};
                    mant_nxt = in_mant;
                    if (in_exp == 5'd31) begin
                        state_nxt = DONE;
                        out_nxt   = (in_mant[11:2] == 10'd0) ? {in_sign, 5'h1F, 10'h000} : 16'h7E00;
                    end else if (in_mant == 14'd0) begin
                        state_nxt = DONE;
                        out_nxt   = {in_sign, 15'h0000};
                    end else if (in_mant[13]) begin
                        state_nxt = RSHIFT;
                    end else if (!in_mant[12]) begin
                        state_nxt = LSHIFT;
                    end else begin
                        state_nxt = ROUND;
                    end
                end
            end
            RSHIFT: begin
                mant_nxt = {1'b0, mant[13:2], mant[1] | mant[0]};
                exp_nxt  = exp_inc;
                if (exp_inc >= 6'd31) begin
                    state_nxt = DONE;
                    out_nxt   = {sign, 5'h1F, 10'h000};
                end else begin
                    state_nxt = ROUND;
                end
            end
            LSHIFT: begin
                // Look ahead at the shifted value so the final shift goes straight to ROUND.
                if (!mant[12] && exp > 6'd1) begin
                    mant_nxt = mant_sh;
                    exp_nxt  = exp_dec;
                    if (mant_sh[12]) begin
                        state_nxt = ROUND;
                    end else if (exp_dec == 6'd1) begin
                        state_nxt = FTZ ? DONE : ROUND;
                        if (FTZ) out_nxt = {sign, 15'h0000};
                    end
                end else if (mant[12]) begin
                    state_nxt = ROUND;
                end else begin
                    state_nxt = FTZ ? DONE : ROUND;
                    if (FTZ) out_nxt = {sign, 15'h0000};
                end
            end
            ROUND: begin
                out_nxt   = round_pack(sign, exp, mant);
                state_nxt = DONE;
            end
            DONE: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_half_norm.sv
// Randomized and directed bench for half_norm against a value-level binary16 normalize/round model.
module tb_half_norm;
    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [4:0]  in_exp = 5'd0;
    logic [13:0] in_mant = 14'd0;
    logic [15:0] out;
    logic        out_valid;
    logic        out_ready = 1'b1;

    int checks = 0;
    int failures = 0;

    half_norm dut (
        .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
        .out(out), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Value-level model: normalize the significand to [4096,8192), round half-to-even on the two low bits.
    function automatic void model(input logic s, input logic [4:0] ei, input logic [13:0] mi,
                                  output logic [15:0] res, output int lat);
        int e, m, q, rem, k;
        logic [31:0] ev, qv;
        e = (ei == 5'd0) ? 1 : int'(ei);
        m = int'(mi);
        if (ei == 5'd31) begin
            res = (mi[11:2] == 10'd0) ? {s, 5'h1F, 10'h000} : 16'h7E00;
            lat = 1;
            return;
        end
        if (m == 0) begin
            res = {s, 15'h0000};
            lat = 1;
            return;
        end
        lat = 2;
        if (m >= 8192) begin
            m = (m / 2) | (m % 2);
            e = e + 1;
            lat = 3;
            if (e >= 31) begin
                res = {s, 5'h1F, 10'h000};
                lat = 2;
                return;
            end
        end else if (m < 4096) begin
            k = 0;
            while (m < 4096 && e > 1) begin
                m = m * 2;
                e = e - 1;
                k++;
            end
            lat = (k == 0) ? 3 : 2 + k;
`ifdef HALF_NORM_FTZ_EN
            if (m < 4096) begin
                res = {s, 15'h0000};
                lat = (k == 0) ? 2 : 1 + k;
                return;
            end
`endif
        end
        q = m / 4;
        rem = m % 4;
        if (rem == 3 || (rem == 2 && (q % 2) == 1)) q = q + 1;
        if (q == 2048) begin
            q = 1024;
            e = e + 1;
        end
        ev = e;
        qv = q;
        if (e >= 31) res = {s, 5'h1F, 10'h000};
        else res = {s, (q >= 1024) ? ev[4:0] : 5'd0, qv[9:0]};
    endfunction

    task automatic txn(input string tag, input logic s, input logic [4:0] e, input logic [13:0] m,
                       input logic [15:0] want, input int want_lat, input int hold);
        int lat;
        @(negedge clk);
        in_sign = s; in_exp = e; in_mant = m; in_valid = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, "_busy"}, in_ready, 1'b0);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, lat, want_lat);
        chk({tag, "_out"}, out, want);
        if (hold > 0) begin
            repeat (hold) begin
                @(posedge clk); #1;
                chk({tag, "_hold_out"}, out, want);
                chk({tag, "_hold_vld"}, out_valid, 1'b1);
                chk({tag, "_hold_rdy"}, in_ready, 1'b0);
            end
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk({tag, "_idle_rdy"}, in_ready, 1'b1);
        chk({tag, "_idle_vld"}, out_valid, 1'b0);
        chk({tag, "_idle_out"}, out, want);
    endtask

    task automatic rand_txn(input int hold);
        logic        s;
        logic [4:0]  e;
        logic [13:0] m;
        logic [15:0] r;
        int          l;
        s = 1'($urandom_range(0, 1));
        e = 5'($urandom_range(0, 31));
        m = 14'($urandom_range(0, 16383) >> $urandom_range(0, 13));
        model(s, e, m, r, l);
        txn("rand", s, e, m, r, l, hold);
    endtask

    initial begin
        #12;
        chk("rst_out", out, 16'h0000);
        chk("rst_vld", out_valid, 1'b0);
        chk("rst_rdy", in_ready, 1'b1);
        @(negedge clk);
        nrst = 1'b1;

        txn("normal", 1'b0, 5'd15, 14'h1000, 16'h3C00, 2, 0);
        txn("carry", 1'b0, 5'd15, 14'h2000, 16'h4000, 3, 0);
        txn("cancel", 1'b0, 5'd15, 14'h0010, 16'h1C00, 10, 0);
        txn("rne_up", 1'b0, 5'd15, 14'h1006, 16'h3C02, 2, 0);
        txn("rne_tie", 1'b0, 5'd15, 14'h1002, 16'h3C00, 2, 0);
        txn("mant_ovf", 1'b0, 5'd15, 14'h1FFE, 16'h4000, 2, 0);
        txn("exp_ovf", 1'b0, 5'd30, 14'h3FFF, 16'h7C00, 2, 0);
        txn("nan", 1'b1, 5'd31, 14'h1004, 16'h7E00, 1, 0);
        txn("inf", 1'b1, 5'd31, 14'h1000, 16'hFC00, 1, 0);
        txn("zero", 1'b1, 5'd9, 14'h0000, 16'h8000, 1, 0);
`ifdef HALF_NORM_FTZ_EN
        txn("subnorm", 1'b0, 5'd1, 14'h0800, 16'h0000, 2, 0);
`else
        txn("subnorm", 1'b0, 5'd1, 14'h0800, 16'h0200, 3, 0);
`endif
        txn("backpr", 1'b1, 5'd20, 14'h1555, 16'hD155, 2, 5);

        // Asynchronous reset in the middle of a long left-shift run.
        @(negedge clk);
        in_sign = 1'b0; in_exp = 5'd15; in_mant = 14'h0010; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        nrst = 1'b0;
        #1;
        chk("arst_out", out, 16'h0000);
        chk("arst_vld", out_valid, 1'b0);
        chk("arst_rdy", in_ready, 1'b1);
        @(negedge clk);
        nrst = 1'b1;
        txn("post_rst", 1'b0, 5'd15, 14'h1006, 16'h3C02, 2, 0);

        for (int i = 0; i < 300; i++) begin
            rand_txn((i % 7 == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
